// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the sized data memory.
package dm_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Byte-lane write strobe for an access of the given size at byte offset lo.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_B:    be = 4'b0001 << lo;
         SZ_H:    be = lo[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Pull the addressed lane(s) out of a memory word, right-align and extend.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[8*lo +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
         SZ_H:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables,
// registered read (read returns the pre-write contents on a same-edge write).
module dm_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Byte-masked write and registered read of the addressed word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dm_sized.sv
// Sized data memory: valid/ready request port, byte/half/word access,
// fault reporting and an optional post-reset zeroing sweep.
//
// state | meaning
// CLEAR | sweep writes zero to word[clr_cnt]; requests not accepted
// RUN   | one request accepted per cycle, response one cycle later
module dm_sized
   import dm_pkg::*;
#(
   parameter int DEPTH        = 1024,
   parameter int ADDR_W       = 32,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              wen,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [ADDR_W-1:0] add,
   input  logic [31:0]       data_in,
   output logic              rsp_valid,
   output logic [31:0]       data_out,
   output logic              fault,
   output logic              busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH);

   state_t            state;
   state_t            state_nxt;
   logic [AW-1:0]     clr_cnt;
   logic              clr_last;
   logic              accept;
   logic [ADDR_W-3:0] widx;
   logic [1:0]        lo;
   logic              flt;
   logic [31:0]       st_data;
   logic [AW-1:0]     ram_addr;
   logic [3:0]        ram_be;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   logic              rsp_valid_q;
   logic              fault_q;
   logic              ld_q;
   logic [1:0]        sz_q;
   logic [1:0]        lo_q;
   logic              uns_q;

   assign clr_last  = (clr_cnt == AW'(DEPTH-1));
   assign busy      = (state == CLEAR);
   // Gated by rst so a reset held in RUN (no sweep) still reports not-ready.
   assign req_ready = (state == RUN) & ~rst;
   assign accept    = req_valid & req_ready;
   assign widx      = add[ADDR_W-1:2];
   assign lo        = add[1:0];

   // State register; reset picks the sweep or goes straight to service.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= CLEAR_ON_RST ? CLEAR : RUN;
      else     state <= state_nxt;
   end

   // Next state: leave the sweep on the edge that writes the last word.
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_last) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = state;
      endcase
   end

   // Sweep index, restarts from zero on every reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 clr_cnt <= '0;
      else if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
   end

   // Fault decode: reserved size, misalignment, or word index past the array.
   always_comb begin
      flt = 1'b0;
      if (size == 2'b11)                flt = 1'b1;
      if (size == SZ_H && lo[0])        flt = 1'b1;
      if (size == SZ_W && lo != 2'b00)  flt = 1'b1;
      if (widx >= DEPTH_L)              flt = 1'b1;
   end

   // Store data replicated across lanes; the strobe picks the real target.
   always_comb begin
      st_data = data_in;
      case (size)
         SZ_B:    st_data = {4{data_in[7:0]}};
         SZ_H:    st_data = {2{data_in[15:0]}};
         default: st_data = data_in;
      endcase
   end

   // RAM port mux: sweep owns the port while busy; nothing is written during reset.
   always_comb begin
      ram_addr  = widx[AW-1:0];
      ram_wdata = st_data;
      ram_be    = 4'b0000;
      if (rst) begin
         ram_be = 4'b0000;
      end else if (busy) begin
         ram_addr  = clr_cnt;
         ram_wdata = '0;
         ram_be    = 4'b1111;
      end else if (accept && wen && !flt) begin
         ram_be = byte_en(size, lo);
      end
   end

   dm_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .be    (ram_be),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Response registers; a reset drops any in-flight response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         fault_q     <= 1'b0;
         ld_q        <= 1'b0;
         sz_q        <= 2'b00;
         lo_q        <= 2'b00;
         uns_q       <= 1'b0;
      end else begin
         rsp_valid_q <= accept;
         fault_q     <= accept & flt;
         ld_q        <= accept & ~wen & ~flt;
         sz_q        <= size;
         lo_q        <= lo;
         uns_q       <= uns;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign fault     = fault_q;
   assign data_out  = ld_q ? load_extract(ram_rdata, sz_q, lo_q, uns_q) : 32'h0;

endmodule

// File: tb/tb_dm_sized.sv
// Self-checking bench for dm_sized (DEPTH=16, CLEAR_ON_RST=1).
module tb_dm_sized;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        wen;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] add;
   logic [31:0] data_in;
   logic        rsp_valid;
   logic [31:0] data_out;
   logic        fault;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Reference: flat byte-addressed image of the 64-byte memory.
   logic [7:0] mem_b [64];

   logic        pend = 1'b0;
   logic [31:0] pend_d;
   logic        pend_f;
   string       pend_name;

   typedef struct packed {
      logic        v;
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] ed;
      logic        ef;
   } vec_t;

   vec_t tab[$];

   dm_sized #(
      .DEPTH        (16),
      .ADDR_W       (32),
      .CLEAR_ON_RST (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .wen       (wen),
      .size      (size),
      .uns       (uns),
      .add       (add),
      .data_in   (data_in),
      .rsp_valid (rsp_valid),
      .data_out  (data_out),
      .fault     (fault),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] ed, input logic ef);
      vec_t t;
      t.v = v; t.w = w; t.sz = sz; t.u = u; t.a = a; t.d = d; t.ed = ed; t.ef = ef;
      return t;
   endfunction

   // Behavioural model: byte-granular little-endian memory, plain arithmetic.
   task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output logic f);
      int n;
      int base;
      logic [31:0] val;
      n    = 1 << sz;
      f    = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 64);
      rd   = 32'h0;
      base = int'(a[5:0]);
      if (!f) begin
         if (w) begin
            for (int k = 0; k < n; k++) mem_b[base + k] = 8'(d >> (8 * k));
         end else begin
            val = 32'h0;
            for (int k = 0; k < n; k++) val = val | (32'(mem_b[base + k]) << (8 * k));
            if (!u && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            rd = val;
         end
      end
   endtask

   // One bus cycle: check the response to the previous request, then drive a new one.
   task automatic do_cycle(input logic v, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d,
                           input bit use_tab, input logic [31:0] td, input logic tf,
                           input string nm);
      logic [31:0] md;
      logic        mf;
      @(negedge clk);
      if (pend) begin
         chk({pend_name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
         chk({pend_name, "_fault"}, 32'(fault), 32'(pend_f));
         chk({pend_name, "_data"}, data_out, pend_d);
      end else begin
         chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      req_valid = v; wen = w; size = sz; uns = u; add = a; data_in = d;
      if (v) begin
         chk({nm, "_ready"}, 32'(req_ready), 32'd1);
         model_access(w, sz, u, a, d, md, mf);
         pend      = 1'b1;
         pend_d    = use_tab ? td : md;
         pend_f    = use_tab ? tf : mf;
         pend_name = nm;
      end else begin
         pend = 1'b0;
      end
   endtask

   // Called at the instant rst is released; counts sampled cycles with busy high.
   task automatic wait_sweep(output int n, output int bad_ready);
      n = 0;
      bad_ready = 0;
      #1;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (req_ready !== 1'b0) bad_ready++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({nm, "_fault"}, 32'(fault), 32'd0);
      chk({nm, "_data_out"}, data_out, 32'd0);
   endtask

   initial begin
      int n;
      int bad;
      logic [31:0] ra;

      rst = 1'b1; req_valid = 1'b0; wen = 1'b0; size = 2'b00; uns = 1'b0;
      add = 32'h0; data_in = 32'h0;
      for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;

      // Reset values and first sweep.
      repeat (3) @(negedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;
      wait_sweep(n, bad);
      chk("sweep_len", 32'(n), 32'd16);
      chk("sweep_ready_low", 32'(bad), 32'd0);
      chk("sweep_ready_after", 32'(req_ready), 32'd1);

      // Directed vectors, issued back-to-back.
      for (int i = 0; i < 16; i++) tab.push_back(mk(1, 0, 2'd2, 0, 32'(4 * i), 0, 32'h0, 0));
      tab.push_back(mk(1, 1, 2'd2, 0, 32'h08, 32'hDEAD_BEEF, 32'h0, 0));
      tab.push_back(mk(0, 0, 2'd0, 0, 32'h00, 0, 32'h0, 0));
      tab.push_back(mk(1, 0, 2'd2, 0, 32'h08, 0, 32'hDEAD_BEEF, 0));
      tab.push_back(mk(1, 1, 2'd0, 0, 32'h05, 32'hAAAA_AA80, 32'h0, 0));
      tab.push_back(mk(1, 0, 2'd0, 0, 32'h05, 0, 32'hFFFF_FF80, 0));
      tab.push_back(mk(1, 0, 2'd0, 1, 32'h05, 0, 32'h0000_0080, 0));
      tab.push_back(mk(1, 1, 2'd1, 0, 32'h06, 32'h5555_8001, 32'h0, 0));
      tab.push_back(mk(1, 0, 2'd2, 0, 32'h04, 0, 32'h8001_8000, 0));
      tab.push_back(mk(1, 0, 2'd1, 0, 32'h06, 0, 32'hFFFF_8001, 0));
      tab.push_back(mk(1, 0, 2'd1, 1, 32'h04, 0, 32'h0000_8000, 0));
      tab.push_back(mk(1, 0, 2'd0, 0, 32'h07, 0, 32'hFFFF_FF80, 0));
      tab.push_back(mk(1, 0, 2'd0, 1, 32'h06, 0, 32'h0000_0001, 0));
      tab.push_back(mk(1, 0, 2'd2, 1, 32'h08, 0, 32'hDEAD_BEEF, 0));
      tab.push_back(mk(1, 0, 2'd1, 0, 32'h03, 0, 32'h0, 1));
      tab.push_back(mk(1, 1, 2'd2, 0, 32'h02, 32'hFFFF_FFFF, 32'h0, 1));
      tab.push_back(mk(1, 1, 2'd3, 0, 32'h00, 32'hFFFF_FFFF, 32'h0, 1));
      tab.push_back(mk(1, 0, 2'd3, 0, 32'h00, 0, 32'h0, 1));
      tab.push_back(mk(1, 1, 2'd2, 0, 32'h40, 32'hFFFF_FFFF, 32'h0, 1));
      tab.push_back(mk(1, 1, 2'd2, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1));
      tab.push_back(mk(1, 1, 2'd1, 0, 32'h01, 32'hFFFF_FFFF, 32'h0, 1));
      tab.push_back(mk(1, 0, 2'd2, 0, 32'h00, 0, 32'h0, 0));
      tab.push_back(mk(1, 1, 2'd2, 0, 32'h0C, 32'h1234_5678, 32'h0, 0));
      tab.push_back(mk(1, 0, 2'd2, 0, 32'h0C, 0, 32'h1234_5678, 0));
      tab.push_back(mk(1, 1, 2'd2, 0, 32'h3C, 32'h1122_3344, 32'h0, 0));
      tab.push_back(mk(1, 0, 2'd2, 0, 32'h3C, 0, 32'h1122_3344, 0));
      tab.push_back(mk(1, 0, 2'd0, 1, 32'h3F, 0, 32'h0000_0011, 0));
      foreach (tab[i])
         do_cycle(tab[i].v, tab[i].w, tab[i].sz, tab[i].u, tab[i].a, tab[i].d,
                  1'b1, tab[i].ed, tab[i].ef, $sformatf("vec%0d", i));

      // Randomized traffic against the byte-level model.
      for (int i = 0; i < 400; i++) begin
         ra = 32'($urandom_range(0, 79));
         if ($urandom_range(0, 15) == 0) ra = ra | (32'h1 << $urandom_range(6, 31));
         do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom(),
                  1'b0, 32'h0, 1'b0, "rnd");
      end
      // Read back every word so the whole image is compared.
      for (int i = 0; i < 16; i++)
         do_cycle(1, 0, 2'd2, 0, 32'(4 * i), 0, 1'b0, 32'h0, 1'b0, "rnd_dump");
      do_cycle(0, 0, 2'd0, 0, 32'h0, 0, 1'b0, 32'h0, 1'b0, "flush");

      // Reset while a load response is in flight.
      do_cycle(1, 0, 2'd2, 0, 32'h08, 0, 1'b0, 32'h0, 1'b0, "pre_rst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_mid_req");
      req_valid = 1'b0;
      pend = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset part-way through the sweep, then a full-length sweep again.
      repeat (7) @(negedge clk);
      chk("mid_sweep_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_mid_sweep");
      @(negedge clk);
      rst = 1'b0;
      wait_sweep(n, bad);
      chk("resweep_len", 32'(n), 32'd16);
      chk("resweep_ready_low", 32'(bad), 32'd0);
      for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;

      for (int i = 0; i < 16; i++)
         do_cycle(1, 0, 2'd2, 0, 32'(4 * i), 0, 1'b0, 32'h0, 1'b0, "post_clear");
      do_cycle(0, 0, 2'd0, 0, 32'h0, 0, 1'b0, 32'h0, 1'b0, "flush");
      do_cycle(0, 0, 2'd0, 0, 32'h0, 0, 1'b0, 32'h0, 1'b0, "flush");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
